// File: rtl/device_protocol_if.sv
// rtl/device_protocol_if.sv - packet, application and status signals of the device protocol engine
interface device_protocol_if;
    logic [6:0]  dev_addr;
    logic [98:0] pkt_from_dec;
    logic        pkt_from_dec_avail;
    logic        pkt_from_dec_corrupt;
    logic [98:0] pkt_to_enc;
    logic        pkt_to_enc_avail;
    logic        pkt_sent;
    logic [63:0] rx_data;
    logic        rx_data_avail;
    logic        rx_ready;
    logic [63:0] tx_data;
    logic        tx_data_avail;
    logic        tx_data_taken;
    logic [7:0]  err_count;

    modport slave (
        input  dev_addr, pkt_from_dec, pkt_from_dec_avail, pkt_from_dec_corrupt,
        input  pkt_sent, rx_ready, tx_data, tx_data_avail,
        output pkt_to_enc, pkt_to_enc_avail, rx_data, rx_data_avail,
        output tx_data_taken, err_count
    );

    modport master (
        output dev_addr, pkt_from_dec, pkt_from_dec_avail, pkt_from_dec_corrupt,
        output pkt_sent, rx_ready, tx_data, tx_data_avail,
        input  pkt_to_enc, pkt_to_enc_avail, rx_data, rx_data_avail,
        input  tx_data_taken, err_count
    );
endinterface

// File: rtl/device_protocol.sv
// rtl/device_protocol.sv - device-side OUT/IN transaction engine with handshakes, timeout and error count
module device_protocol (
    input  logic              clk,
    input  logic              rst_b,
    device_protocol_if.slave  bus
);
    localparam logic [7:0]  SYNC        = 8'h01;
    localparam logic [7:0]  PID_OUT     = 8'hE1;
    localparam logic [7:0]  PID_IN      = 8'h69;
    localparam logic [7:0]  PID_DATA0   = 8'hC3;
    localparam logic [7:0]  PID_ACK     = 8'hD2;
    localparam logic [7:0]  PID_NAK     = 8'h5A;
    localparam logic [15:0] HS_ACK      = {SYNC, PID_ACK};
    localparam logic [15:0] HS_NAK      = {SYNC, PID_NAK};
    localparam logic [7:0]  TIMEOUT_LEN = 8'd24;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_OUT_DATA = 3'd1;
    localparam logic [2:0] ST_OUT_HS   = 3'd2;
    localparam logic [2:0] ST_IN_DATA  = 3'd3;
    localparam logic [2:0] ST_IN_HS    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  err_q, err_d;
    logic [63:0] rx_data_q, rx_data_d;
    logic        rx_avail_q, rx_avail_d;
    logic        hs_ack_q, hs_ack_d;
    logic        taken_q, taken_d;
    logic        err_inc;

    logic        pkt_valid;
    logic        pkt_good;
    logic [7:0]  pkt_pid;
    logic [15:0] pkt_hs;
    logic [6:0]  pkt_addr;
    logic [63:0] pkt_payload;
    logic        timeout;
    logic        enc_active;
    logic [98:0] enc_pkt;
    logic        unused_pkt_bits;

    assign pkt_valid   = bus.pkt_from_dec_avail;
    assign pkt_good    = bus.pkt_from_dec_avail && !bus.pkt_from_dec_corrupt;
    assign pkt_pid     = bus.pkt_from_dec[90:83];
    assign pkt_hs      = bus.pkt_from_dec[98:83];
    assign pkt_addr    = bus.pkt_from_dec[82:76];
    assign pkt_payload = bus.pkt_from_dec[82:19];
    assign timeout     = (tmo_q == TIMEOUT_LEN);
    assign unused_pkt_bits = ^bus.pkt_from_dec[18:0];

    // A received packet is always examined before the timeout, so an arrival
    // in the expiry cycle still completes the transaction.
    always_comb begin
        state_d    = state_q;
        rx_data_d  = rx_data_q;
        rx_avail_d = 1'b0;
        hs_ack_d   = hs_ack_q;
        taken_d    = 1'b0;
        err_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pkt_good && pkt_addr == bus.dev_addr) begin
                    if (pkt_pid == PID_OUT) begin
                        state_d = ST_OUT_DATA;
                    end else if (pkt_pid == PID_IN) begin
                        state_d = ST_IN_DATA;
                    end
                end
            end
            ST_OUT_DATA: begin
                if (pkt_valid && bus.pkt_from_dec_corrupt) begin
                    state_d = ST_IDLE;
                    err_inc = 1'b1;
                end else if (pkt_good && pkt_pid == PID_DATA0) begin
                    state_d  = ST_OUT_HS;
                    hs_ack_d = bus.rx_ready;
                    if (bus.rx_ready) begin
                        rx_avail_d = 1'b1;
                        rx_data_d  = pkt_payload;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    err_inc = 1'b1;
                end
            end
            ST_OUT_HS: begin
                if (bus.pkt_sent) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IN_DATA: begin
                if (bus.pkt_sent) begin
                    state_d = bus.tx_data_avail ? ST_IN_HS : ST_IDLE;
                end
            end
            ST_IN_HS: begin
                if (pkt_valid) begin
                    state_d = ST_IDLE;
                    if (!bus.pkt_from_dec_corrupt && pkt_hs == HS_ACK) begin
                        taken_d = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    err_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tmo_d = 8'd0;
        if (state_d == state_q && (state_q == ST_OUT_DATA || state_q == ST_IN_HS)) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    assign err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            tmo_q      <= 8'd0;
            err_q      <= 8'd0;
            rx_data_q  <= 64'd0;
            rx_avail_q <= 1'b0;
            hs_ack_q   <= 1'b0;
            taken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            rx_data_q  <= rx_data_d;
            rx_avail_q <= rx_avail_d;
            hs_ack_q   <= hs_ack_d;
            taken_q    <= taken_d;
        end
    end

    // The request drops in the very cycle the encoder reports consumption.
    assign enc_active = (state_q == ST_OUT_HS || state_q == ST_IN_DATA) && !bus.pkt_sent;

    always_comb begin
        enc_pkt = 99'd0;
        if (enc_active) begin
            if (state_q == ST_OUT_HS) begin
                enc_pkt = {(hs_ack_q ? HS_ACK : HS_NAK), 83'd0};
            end else if (bus.tx_data_avail) begin
                enc_pkt = {SYNC, PID_DATA0, bus.tx_data, 19'd0};
            end else begin
                enc_pkt = {HS_NAK, 83'd0};
            end
        end
    end

    assign bus.pkt_to_enc       = enc_pkt;
    assign bus.pkt_to_enc_avail = enc_active;
    assign bus.rx_data          = rx_data_q;
    assign bus.rx_data_avail    = rx_avail_q;
    assign bus.tx_data_taken    = taken_q;
    assign bus.err_count        = err_q;
endmodule
